// File: rtl/dm_bridge_if.sv
// Core-side and SRAM-side bundles for dm_bridge. In each one the master is
// the side that originates the access.
interface dm_core_if;
  logic        ram_ce_i;
  logic        ram_we_i;
  logic [31:0] ram_addr_i;
  logic [3:0]  ram_sel_i;
  logic [31:0] ram_data_i;
  logic [31:0] ram_data_o;
  logic        stall_o;
  logic        err_o;

  modport master (
    output ram_ce_i, ram_we_i, ram_addr_i, ram_sel_i, ram_data_i,
    input  ram_data_o, stall_o, err_o
  );
  modport slave (
    input  ram_ce_i, ram_we_i, ram_addr_i, ram_sel_i, ram_data_i,
    output ram_data_o, stall_o, err_o
  );
endinterface

interface dm_mem_if;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_sel_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_sel_o, mem_wdata_o,
    input  mem_rdata_i, mem_ack_i
  );
  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_sel_o, mem_wdata_o,
    output mem_rdata_i, mem_ack_i
  );
endinterface

// File: rtl/dm_bridge.sv
// Bridges the core's zero-latency data port onto a req/ack SRAM controller,
// stalling the core while an access is in flight and bounding it with a timeout.
module dm_bridge #(
  parameter int unsigned MEM_BYTES = 4096,
  parameter int unsigned TIMEOUT   = 16,
  parameter logic [31:0] ERR_DATA  = 32'hDEADBEEF
) (
  input  logic      clk,
  input  logic      rst,
  dm_core_if.slave  core,
  dm_mem_if.master  mem
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int unsigned    CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [31:0]    MEM_LIMIT = 32'(MEM_BYTES);

  logic [1:0]       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             in_range;

  assign in_range = core.ram_addr_i < MEM_LIMIT;

  // Gated by reset so an abandoned access releases the core immediately.
  assign core.stall_o = rst && (((state_reg == IDLE) && core.ram_ce_i) ||
                                (state_reg == BUSY));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg        <= IDLE;
      cnt_reg          <= '0;
      mem.mem_req_o    <= 1'b0;
      mem.mem_we_o     <= 1'b0;
      mem.mem_addr_o   <= 32'h0;
      mem.mem_sel_o    <= 4'b0;
      mem.mem_wdata_o  <= 32'h0;
      core.ram_data_o  <= 32'h0;
      core.err_o       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (core.ram_ce_i) begin
            if (in_range) begin
              mem.mem_we_o    <= core.ram_we_i;
              mem.mem_addr_o  <= {core.ram_addr_i[31:2], 2'b00};
              mem.mem_sel_o   <= core.ram_sel_i;
              mem.mem_wdata_o <= core.ram_data_i;
              mem.mem_req_o   <= 1'b1;
              cnt_reg         <= '0;
              state_reg       <= BUSY;
            end else begin
              if (!core.ram_we_i) begin
                core.ram_data_o <= 32'h0;
              end
              core.err_o <= 1'b1;
              state_reg  <= DONE;
            end
          end
        end
        BUSY: begin
          cnt_reg <= cnt_reg + 1'b1;
          // Ack is checked first so an ack on the last allowed cycle still counts.
          if (mem.mem_ack_i) begin
            mem.mem_req_o <= 1'b0;
            if (!mem.mem_we_o) begin
              core.ram_data_o <= mem.mem_rdata_i;
            end
            state_reg <= DONE;
          end else if (cnt_reg == TMO_LAST) begin
            mem.mem_req_o <= 1'b0;
            if (!mem.mem_we_o) begin
              core.ram_data_o <= ERR_DATA;
            end
            core.err_o <= 1'b1;
            state_reg  <= DONE;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_bridge.sv
// Scoreboard bench for dm_bridge: a directed stimulus process pushes expected
// completions, an SRAM responder models ack latency, and a monitor checks each completion.
module tb_dm_bridge;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        err;
    int          stalls;
    int          reqs;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] wdata;
  } exp_t;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  exp_t exp_q[$];

  int          ack_lat;
  logic [31:0] ack_data;
  logic        noise;

  dm_core_if core_if();
  dm_mem_if  mem_if();

  dm_bridge dut (
    .clk  (clk),
    .rst  (rst),
    .core (core_if),
    .mem  (mem_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // SRAM controller model: ack arrives on BUSY cycle index ack_lat (-1 = never).
  initial begin
    int busy_cnt;
    busy_cnt = 0;
    mem_if.mem_ack_i   = 1'b0;
    mem_if.mem_rdata_i = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst || !mem_if.mem_req_o) begin
        busy_cnt           = 0;
        mem_if.mem_ack_i   = noise && rst;
        mem_if.mem_rdata_i = 32'h5A5A5A5A;
      end else begin
        if (busy_cnt == ack_lat) begin
          mem_if.mem_ack_i   = 1'b1;
          mem_if.mem_rdata_i = ack_data;
        end else begin
          mem_if.mem_ack_i   = 1'b0;
          mem_if.mem_rdata_i = 32'hFFFFFFFF;
        end
        busy_cnt++;
      end
    end
  end

  // Monitor: a completion is the first non-stalled cycle after stalled ones.
  initial begin
    int          stalls;
    int          reqs;
    logic        stable;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic [3:0]  c_sel;
    logic        c_we;
    exp_t        e;
    stalls = 0; reqs = 0; stable = 1'b1;
    c_addr = '0; c_wdata = '0; c_sel = '0; c_we = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        stalls = 0; reqs = 0; stable = 1'b1;
      end else begin
        if (mem_if.mem_req_o) begin
          if (reqs == 0) begin
            c_addr = mem_if.mem_addr_o; c_sel = mem_if.mem_sel_o;
            c_we = mem_if.mem_we_o; c_wdata = mem_if.mem_wdata_o;
          end else if (c_addr !== mem_if.mem_addr_o || c_sel !== mem_if.mem_sel_o ||
                       c_we !== mem_if.mem_we_o || c_wdata !== mem_if.mem_wdata_o) begin
            stable = 1'b0;
          end
          reqs++;
        end
        if (core_if.stall_o) begin
          stalls++;
        end else if (stalls > 0) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_completion: got data=%h with empty queue", core_if.ram_data_o);
          end else begin
            e = exp_q.pop_front();
            $display("txn %s: data=%h err=%b stalls=%0d reqs=%0d addr=%h",
                     e.name, core_if.ram_data_o, core_if.err_o, stalls, reqs, c_addr);
            chk({e.name, ".data"},   core_if.ram_data_o, e.data);
            chk({e.name, ".err"},    32'(core_if.err_o), 32'(e.err));
            chk({e.name, ".stalls"}, 32'(stalls), 32'(e.stalls));
            chk({e.name, ".reqs"},   32'(reqs), 32'(e.reqs));
            if (e.reqs > 0) begin
              chk({e.name, ".addr"},   c_addr, e.addr);
              chk({e.name, ".sel"},    32'(c_sel), 32'(e.sel));
              chk({e.name, ".we"},     32'(c_we), 32'(e.we));
              chk({e.name, ".wdata"},  c_wdata, e.wdata);
              chk({e.name, ".stable"}, 32'(stable), 32'd1);
            end
          end
          stalls = 0; reqs = 0; stable = 1'b1;
        end
      end
    end
  end

  // Drives one access starting right after a rising edge and returns in its DONE cycle.
  task automatic access(input string name, input logic we, input logic [31:0] addr,
                        input logic [3:0] sel, input logic [31:0] wd, input int lat,
                        input logic [31:0] rd, input logic [31:0] e_data, input logic e_err,
                        input int e_stalls, input int e_reqs, input logic drop);
    exp_t e;
    int   n;
    e.name = name; e.data = e_data; e.err = e_err; e.stalls = e_stalls; e.reqs = e_reqs;
    e.addr = {addr[31:2], 2'b00}; e.sel = sel; e.we = we; e.wdata = wd;
    exp_q.push_back(e);
    ack_lat  = lat;
    ack_data = rd;
    core_if.ram_ce_i   = 1'b1;
    core_if.ram_we_i   = we;
    core_if.ram_addr_i = addr;
    core_if.ram_sel_i  = sel;
    core_if.ram_data_i = wd;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (core_if.stall_o && n < 100);
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL %s.timeout: got stall after %0d cycles expected completion", name, n);
    end
    if (drop) core_if.ram_ce_i = 1'b0;
  endtask

  initial begin
    errors = 0; checks = 0; noise = 1'b0;
    ack_lat = -1; ack_data = 32'h0;
    rst = 1'b0;
    core_if.ram_ce_i = 1'b0; core_if.ram_we_i = 1'b0; core_if.ram_addr_i = 32'h0;
    core_if.ram_sel_i = 4'h0; core_if.ram_data_i = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.req",   32'(mem_if.mem_req_o), 32'd0);
    chk("reset.stall", 32'(core_if.stall_o), 32'd0);
    chk("reset.data",  core_if.ram_data_o, 32'h0);
    chk("reset.err",   32'(core_if.err_o), 32'd0);
    chk("reset.addr",  mem_if.mem_addr_o, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    //       name          we    addr          sel      wdata         lat rdata         exp data      err  st  rq drop
    access("load_imm",   1'b0, 32'h0000_0010, 4'hF,   32'h1111_1111, 0,  32'h1234_5678, 32'h1234_5678, 1'b0, 2,  1, 1'b1);
    access("store_lat3", 1'b1, 32'h0000_0023, 4'b1000, 32'hAB00_0000, 2,  32'h7777_7777, 32'h1234_5678, 1'b0, 4,  3, 1'b1);
    access("tie",        1'b0, 32'h0000_0100, 4'hF,   32'h0,         15, 32'h0000_0005, 32'h0000_0005, 1'b0, 17, 16, 1'b1);
    access("oor_load",   1'b0, 32'h0000_1000, 4'hF,   32'h0,         0,  32'h0,         32'h0,         1'b1, 1,  0, 1'b1);
    access("timeout",    1'b0, 32'h0000_0200, 4'hF,   32'h0,         -1, 32'h0,         32'hDEAD_BEEF, 1'b1, 17, 16, 1'b1);
    access("oor_store",  1'b1, 32'hFFFF_FFFC, 4'hF,   32'h1357_9BDF, 0,  32'h0,         32'hDEAD_BEEF, 1'b1, 1,  0, 1'b1);

    // Abandon an in-flight load with reset while the core still requests.
    ack_lat = -1;
    core_if.ram_ce_i = 1'b1; core_if.ram_we_i = 1'b0;
    core_if.ram_addr_i = 32'h40; core_if.ram_sel_i = 4'hF;
    repeat (4) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("midrst.req",   32'(mem_if.mem_req_o), 32'd0);
    chk("midrst.stall", 32'(core_if.stall_o), 32'd0);
    chk("midrst.data",  core_if.ram_data_o, 32'h0);
    chk("midrst.err",   32'(core_if.err_o), 32'd0);
    core_if.ram_ce_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    noise = 1'b1;
    @(posedge clk); #1;

    access("b2b_a", 1'b0, 32'h0000_0FFF, 4'hF,  32'h0, 1, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 3, 2, 1'b0);
    access("b2b_b", 1'b0, 32'h0000_0004, 4'h0,  32'h0, 0, 32'h0BAD_C0DE, 32'h0BAD_C0DE, 1'b0, 2, 1, 1'b1);
    noise = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dm_bridge.md
Name: dm_bridge

Overview:
- Data-bus bridge between the core's data-memory port (ram_* signals) and a variable-latency data SRAM controller using a req/ack handshake.
- Freezes the core with a stall while an access is in flight and returns read data on completion.
- Rejects out-of-range addresses and bounds each access with a timeout.
- Sits directly downstream of the core's ram port, in place of the zero-latency data memory.

Parameters:
- MEM_BYTES, 4096, size of the mapped data region in bytes; valid addresses are 0 .. MEM_BYTES-1.
- TIMEOUT, 16, maximum cycles spent in BUSY waiting for mem_ack before the access is aborted.
- ERR_DATA, 32'hDEADBEEF, read data returned on a timeout.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- ram_ce_i  in  1  core access request
- ram_we_i  in  1  1 = store, 0 = load
- ram_addr_i  in  32  byte address from core
- ram_sel_i  in  4  byte lanes
- ram_data_i  in  32  store data from core
- ram_data_o  out  32  load data to core
- stall_o  out  1  core must hold its pipeline
- err_o  out  1  sticky error flag
- mem_req_o  out  1  request to SRAM controller
- mem_we_o  out  1  latched we
- mem_addr_o  out  32  latched word address (byte address with [1:0] forced to 0)
- mem_sel_o  out  4  latched sel
- mem_wdata_o  out  32  latched store data
- mem_rdata_i  in  32  SRAM read data, valid when mem_ack_i=1
- mem_ack_i  in  1  access complete

Behaviour:
- Reset (rst=0, asynchronous) forces:
  - state=IDLE.
  - mem_req_o, mem_we_o, err_o = 0.
  - mem_addr_o, mem_wdata_o, ram_data_o = 0; mem_sel_o = 4'b0.
  - Timeout counter = 0.
- Reset mid-access abandons the request immediately; mem_req_o drops asynchronously.
- stall_o is combinational: 1 when (state==IDLE && ram_ce_i) or state==BUSY; 0 in DONE and in idle with no request.
- State IDLE:
  - ram_ce_i=1 with ram_addr_i < MEM_BYTES: latch we, word address, sel and store data into the mem_* registers; assert mem_req_o; clear counter; go BUSY.
  - ram_ce_i=1 with ram_addr_i >= MEM_BYTES: no SRAM request; load ram_data_o=0; set err_o; go DONE.
  - ram_ce_i=1 with ram_sel_i==0: treat as valid; forward unchanged.
- State BUSY:
  - mem_req_o and all mem_* outputs stay stable until ack.
  - Counter increments each cycle.
  - mem_ack_i=1: drop mem_req_o next edge. On a load, register mem_rdata_i into ram_data_o; on a store, leave ram_data_o unchanged. Go DONE.
  - No ack and counter==TIMEOUT-1: drop mem_req_o; ram_data_o=ERR_DATA on a load; set err_o; go DONE.
  - Ack and timeout in the same cycle: ack wins, no error.
- State DONE:
  - Exactly one cycle, stall_o=0; the core consumes ram_data_o and advances.
  - Always returns to IDLE; ram_ce_i in DONE is ignored.
  - A new request is seen in the following IDLE cycle.
- Latency, with ack on the first BUSY cycle: request cycle → BUSY → DONE gives 2 stall cycles, data on the 3rd cycle.
  - Every extra wait cycle adds one stall cycle.
- ram_data_o holds its last value outside DONE.
- err_o is cleared only by reset.
- mem_ack_i outside BUSY is ignored.
- A store never alters ram_data_o.

Test Plan:
- Load, immediate ack: addr=0x10, ack in first BUSY cycle with rdata=0x12345678 → mem_addr_o=0x10; stall high 2 cycles; ram_data_o=0x12345678 in DONE; err_o=0.
- Store, 3-cycle ack latency: addr=0x23, sel=4'b1000, data=0xAB000000 → mem_addr_o=0x20, mem_sel_o=4'b1000, mem_we_o=1, fields stable 3 cycles; stall 4 cycles; ram_data_o unchanged.
- Out of range: addr=MEM_BYTES (0x1000) load → mem_req_o never asserts; 1 stall cycle; ram_data_o=0; err_o=1 and remains set.
- Timeout: load, ack never arrives → mem_req_o high exactly 16 BUSY cycles; then DONE with ram_data_o=0xDEADBEEF and err_o=1.
- Ack-timeout tie: ack on the 16th BUSY cycle with rdata=0x5 → ram_data_o=0x5, err_o=0.
- Reset mid-access: rst=0 during BUSY → mem_req_o=0 and stall_o=0 asynchronously; after release, back-to-back loads each complete with correct data and no spurious ack use.
